// File: rtl/pss_pkg.sv
// Shared types and constants for the PSS search controller.
package pss_pkg;

  localparam int unsigned N_ID_2_NUM = 3;
  localparam int unsigned ID_DW      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2,
    TRACK  = 2'd3
  } pss_state_t;

  function automatic logic [N_ID_2_NUM-1:0] id_onehot(input logic [ID_DW-1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/pss_peak_max.sv
// Combinational arg-max over the enabled correlator lanes; ties resolve to the lower N_ID_2.
module pss_peak_max
  import pss_pkg::*;
#(
  parameter int unsigned IN_DW = 24
) (
  input  logic [N_ID_2_NUM*IN_DW-1:0] lanes_i,
  input  logic [N_ID_2_NUM-1:0]       mask_i,
  output logic [ID_DW-1:0]            id_c,
  output logic [IN_DW-1:0]            mag_c
);

  always_comb begin
    id_c  = '0;
    mag_c = '0;
    for (int unsigned k = 0; k < N_ID_2_NUM; k++) begin
      if (mask_i[k] && (lanes_i[k*IN_DW +: IN_DW] > mag_c)) begin
        id_c  = ID_DW'(k);
        mag_c = lanes_i[k*IN_DW +: IN_DW];
      end
    end
  end

endmodule

// File: rtl/pss_search_ctrl.sv
// PSS cell search / tracking sequencer: SEARCH over all correlators, refine in HOLD,
// then track the detected N_ID_2 once per SSB period until too many misses.
module pss_search_ctrl
  import pss_pkg::*;
#(
  parameter int unsigned IN_DW      = 24,
  parameter int unsigned PERIOD_LEN = 76800,
  parameter int unsigned HOLD_LEN   = 8,
  parameter int unsigned WINDOW     = 4,
  parameter int unsigned MAX_MISSES = 3,
  localparam int unsigned CNT_DW    = $clog2(PERIOD_LEN)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        search_en_i,
  input  logic [IN_DW-1:0]            threshold_i,
  input  logic [N_ID_2_NUM*IN_DW-1:0] s_axis_corr_tdata,
  input  logic                        s_axis_corr_tvalid,
  output logic [N_ID_2_NUM-1:0]       corr_en_o,
  output logic                        m_axis_peak_tvalid,
  output logic [ID_DW-1:0]            m_axis_peak_tdata,
  output logic [CNT_DW-1:0]           peak_pos_o,
  output logic [IN_DW-1:0]            peak_mag_o,
  output logic [1:0]                  state_o,
  output logic                        sync_lost_o
);

  localparam int unsigned HC_DW    = (HOLD_LEN > 2) ? $clog2(HOLD_LEN) : 1;
  localparam int unsigned MS_DW    = $clog2(MAX_MISSES + 1);
  localparam int unsigned SW       = CNT_DW + 1;
  localparam int unsigned W_MOD    = WINDOW % PERIOD_LEN;
  localparam bit          FULL_WIN = (PERIOD_LEN <= 2 * WINDOW + 1);
  localparam logic [CNT_DW-1:0] LAST_POS  = CNT_DW'(PERIOD_LEN - 1);
  localparam logic [SW-1:0]     P_EXT     = SW'(PERIOD_LEN);
  localparam logic [SW-1:0]     W_EXT     = SW'(W_MOD);
  localparam logic [HC_DW-1:0]  HOLD_LAST = HC_DW'((HOLD_LEN >= 2) ? HOLD_LEN - 2 : 0);
  localparam logic [MS_DW-1:0]  MISS_LAST = MS_DW'((MAX_MISSES >= 1) ? MAX_MISSES - 1 : 0);

  pss_state_t             state_q, state_d;
  logic [CNT_DW-1:0]      cnt_q, cnt_d;
  logic [HC_DW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [MS_DW-1:0]       misses_q, misses_d;
  logic [ID_DW-1:0]       pk_id_q, pk_id_d;
  logic [CNT_DW-1:0]      pk_pos_q, pk_pos_d;
  logic [IN_DW-1:0]       pk_mag_q, pk_mag_d;
  logic                   armed_q, armed_d;
  logic                   best_vld_q, best_vld_d;
  logic [CNT_DW-1:0]      best_pos_q, best_pos_d;
  logic [IN_DW-1:0]       best_mag_q, best_mag_d;
  logic [N_ID_2_NUM-1:0]  corr_en_q, corr_en_d;
  logic                   peak_vld_q, peak_vld_d;
  logic [ID_DW-1:0]       out_id_q, out_id_d;
  logic [CNT_DW-1:0]      out_pos_q, out_pos_d;
  logic [IN_DW-1:0]       out_mag_q, out_mag_d;
  logic                   sync_lost_q, sync_lost_d;

  logic [N_ID_2_NUM-1:0]  lane_mask_c;
  logic [ID_DW-1:0]       max_id_c;
  logic [IN_DW-1:0]       max_mag_c;
  logic                   cross_c;
  logic [CNT_DW-1:0]      cnt_inc_c;
  logic [SW-1:0]          sum_end_c, sum_start_c;
  logic [CNT_DW-1:0]      win_end_c, win_start_c;
  logic                   in_win_c, at_end_c, take_c, emit_c;

  // Only the tracked correlator is evaluated once a cell is found.
  assign lane_mask_c = (state_q == TRACK) ? id_onehot(pk_id_q) : 3'b111;

  pss_peak_max #(.IN_DW(IN_DW)) u_peak_max (
    .lanes_i (s_axis_corr_tdata),
    .mask_i  (lane_mask_c),
    .id_c    (max_id_c),
    .mag_c   (max_mag_c)
  );

  assign cross_c   = max_mag_c > threshold_i;
  assign cnt_inc_c = (cnt_q == LAST_POS) ? '0 : cnt_q + CNT_DW'(1);

  // Window bounds around E modulo the period; a full-period window starts right after its end.
  assign sum_end_c   = {1'b0, pk_pos_q} + W_EXT;
  assign win_end_c   = (sum_end_c >= P_EXT) ? CNT_DW'(sum_end_c - P_EXT) : CNT_DW'(sum_end_c);
  assign sum_start_c = {1'b0, pk_pos_q} + P_EXT - W_EXT;
  always_comb begin
    if (FULL_WIN) win_start_c = (win_end_c == LAST_POS) ? '0 : win_end_c + CNT_DW'(1);
    else win_start_c = (sum_start_c >= P_EXT) ? CNT_DW'(sum_start_c - P_EXT) : CNT_DW'(sum_start_c);
  end

  // A window is only judged once its start has been seen, so entering TRACK never counts a partial window.
  assign in_win_c = armed_q || (cnt_q == win_start_c);
  assign at_end_c = in_win_c && (cnt_q == win_end_c);
  assign take_c   = in_win_c && cross_c && (!best_vld_q || (max_mag_c > best_mag_q));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_cnt_d  = hold_cnt_q;
    misses_d    = misses_q;
    pk_id_d     = pk_id_q;
    pk_pos_d    = pk_pos_q;
    pk_mag_d    = pk_mag_q;
    armed_d     = armed_q;
    best_vld_d  = best_vld_q;
    best_pos_d  = best_pos_q;
    best_mag_d  = best_mag_q;
    peak_vld_d  = 1'b0;
    out_id_d    = out_id_q;
    out_pos_d   = out_pos_q;
    out_mag_d   = out_mag_q;
    sync_lost_d = 1'b0;
    emit_c      = 1'b0;
    corr_en_d   = 3'b111;

    unique case (state_q)
      IDLE: begin
        if (search_en_i) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      end
      SEARCH: begin
        if (s_axis_corr_tvalid) begin
          cnt_d = cnt_inc_c;
          if (cross_c) begin
            pk_id_d    = max_id_c;
            pk_pos_d   = cnt_q;
            pk_mag_d   = max_mag_c;
            hold_cnt_d = '0;
            if (HOLD_LEN <= 1) begin
              emit_c     = 1'b1;
              state_d    = TRACK;
              armed_d    = 1'b0;
              best_vld_d = 1'b0;
              misses_d   = '0;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (s_axis_corr_tvalid) begin
          cnt_d = cnt_inc_c;
          if (max_mag_c > pk_mag_q) begin
            pk_id_d  = max_id_c;
            pk_pos_d = cnt_q;
            pk_mag_d = max_mag_c;
          end
          if (hold_cnt_q == HOLD_LAST) begin
            emit_c     = 1'b1;
            state_d    = TRACK;
            armed_d    = 1'b0;
            best_vld_d = 1'b0;
            misses_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_DW'(1);
          end
        end
      end
      TRACK: begin
        if (s_axis_corr_tvalid) begin
          cnt_d = cnt_inc_c;
          if (in_win_c) armed_d = 1'b1;
          if (take_c) begin
            best_vld_d = 1'b1;
            best_pos_d = cnt_q;
            best_mag_d = max_mag_c;
          end
          if (at_end_c) begin
            armed_d    = 1'b0;
            best_vld_d = 1'b0;
            if (best_vld_q || take_c) begin
              emit_c   = 1'b1;
              pk_pos_d = best_pos_d;
              pk_mag_d = best_mag_d;
              misses_d = '0;
            end else if (misses_q == MISS_LAST) begin
              sync_lost_d = 1'b1;
              state_d     = SEARCH;
              cnt_d       = '0;
              misses_d    = '0;
            end else begin
              misses_d = misses_q + MS_DW'(1);
            end
          end
        end
      end
      default: ;
    endcase

    if (emit_c && search_en_i) begin
      peak_vld_d = 1'b1;
      out_id_d   = pk_id_d;
      out_pos_d  = pk_pos_d;
      out_mag_d  = pk_mag_d;
    end

    if (!search_en_i) begin
      state_d     = IDLE;
      sync_lost_d = 1'b0;
    end

    if (state_d == IDLE) corr_en_d = 3'b000;
    else if (state_d == TRACK) corr_en_d = id_onehot(pk_id_d);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_cnt_q  <= '0;
      misses_q    <= '0;
      pk_id_q     <= '0;
      pk_pos_q    <= '0;
      pk_mag_q    <= '0;
      armed_q     <= 1'b0;
      best_vld_q  <= 1'b0;
      best_pos_q  <= '0;
      best_mag_q  <= '0;
      corr_en_q   <= '0;
      peak_vld_q  <= 1'b0;
      out_id_q    <= '0;
      out_pos_q   <= '0;
      out_mag_q   <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      misses_q    <= misses_d;
      pk_id_q     <= pk_id_d;
      pk_pos_q    <= pk_pos_d;
      pk_mag_q    <= pk_mag_d;
      armed_q     <= armed_d;
      best_vld_q  <= best_vld_d;
      best_pos_q  <= best_pos_d;
      best_mag_q  <= best_mag_d;
      corr_en_q   <= corr_en_d;
      peak_vld_q  <= peak_vld_d;
      out_id_q    <= out_id_d;
      out_pos_q   <= out_pos_d;
      out_mag_q   <= out_mag_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign corr_en_o          = corr_en_q;
  assign m_axis_peak_tvalid = peak_vld_q;
  assign m_axis_peak_tdata  = out_id_q;
  assign peak_pos_o         = out_pos_q;
  assign peak_mag_o         = out_mag_q;
  assign state_o            = state_q;
  assign sync_lost_o        = sync_lost_q;

endmodule

// File: tb/tb_pss_search_ctrl.sv
// Self-checking bench for pss_search_ctrl: directed scenarios plus randomized
// detect-then-track runs compared against an array-based reference.
module tb_pss_search_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        search_en;
  logic [15:0] thr;
  logic [47:0] tdata;
  logic        tvalid;
  logic [2:0]  corr_en;
  logic        pk_vld;
  logic [1:0]  pk_id;
  logic [5:0]  pk_pos;
  logic [15:0] pk_mag;
  logic [1:0]  state;
  logic        lost;

  int checks = 0;
  int errors = 0;
  int smp [160][3];

  pss_search_ctrl #(
    .IN_DW(16), .PERIOD_LEN(64), .HOLD_LEN(4), .WINDOW(2), .MAX_MISSES(2)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (rst_n),
    .search_en_i        (search_en),
    .threshold_i        (thr),
    .s_axis_corr_tdata  (tdata),
    .s_axis_corr_tvalid (tvalid),
    .corr_en_o          (corr_en),
    .m_axis_peak_tvalid (pk_vld),
    .m_axis_peak_tdata  (pk_id),
    .peak_pos_o         (pk_pos),
    .peak_mag_o         (pk_mag),
    .state_o            (state),
    .sync_lost_o        (lost)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic cycle(input logic v, input int a, input int b, input int c);
    @(negedge clk);
    tvalid = v;
    tdata  = {16'(c), 16'(b), 16'(a)};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tvalid = 1'b0; search_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state); end
    checks++; if (corr_en !== 3'b000) begin errors++; $display("FAIL rst_corr: got %b exp 000", corr_en); end
    checks++; if ({pk_vld, pk_id, pk_pos, pk_mag, lost} !== '0) begin
      errors++; $display("FAIL rst_outs: got vld=%b id=%0d pos=%0d mag=%0d lost=%b exp all 0", pk_vld, pk_id, pk_pos, pk_mag, lost);
    end
    @(negedge clk);
    rst_n = 1'b1; search_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL en_state: got %0d exp 1", state); end
    checks++; if (corr_en !== 3'b111) begin errors++; $display("FAIL en_corr: got %b exp 111", corr_en); end
    thr = 16'd100;
    cycle(1'b1, 0, 150, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL hold_state: got %0d exp 2", state); end
    cycle(1'b1, 0, 0, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d exp 0", state); end
    checks++; if (corr_en !== 3'b000) begin errors++; $display("FAIL async_corr: got %b exp 000", corr_en); end
    checks++; if ({pk_vld, lost} !== 2'b00) begin errors++; $display("FAIL async_strobes: got vld=%b lost=%b exp 0 0", pk_vld, lost); end
  endtask

  task automatic test_detection();
    do_reset();
    thr = 16'd100;
    for (int p = 0; p <= 13; p++) begin
      cycle(1'b1, 0, (p == 10) ? 150 : (p == 12) ? 300 : 0, (p == 11) ? 200 : 0);
      checks++; if (pk_vld !== (p == 13)) begin errors++; $display("FAIL det_vld p=%0d: got %b exp %b", p, pk_vld, (p == 13)); end
    end
    checks++; if (pk_id !== 2'd1) begin errors++; $display("FAIL det_id: got %0d exp 1", pk_id); end
    checks++; if (pk_pos !== 6'd12) begin errors++; $display("FAIL det_pos: got %0d exp 12", pk_pos); end
    checks++; if (pk_mag !== 16'd300) begin errors++; $display("FAIL det_mag: got %0d exp 300", pk_mag); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL det_state: got %0d exp 3", state); end
    checks++; if (corr_en !== 3'b010) begin errors++; $display("FAIL det_corr: got %b exp 010", corr_en); end
  endtask

  task automatic test_tie();
    do_reset();
    thr = 16'd100;
    for (int p = 0; p <= 8; p++) begin
      int v;
      v = (p == 5) ? 500 : 0;
      cycle(1'b1, v, v, v);
      checks++; if (pk_vld !== (p == 8)) begin errors++; $display("FAIL tie_vld p=%0d: got %b exp %b", p, pk_vld, (p == 8)); end
    end
    checks++; if (pk_id !== 2'd0) begin errors++; $display("FAIL tie_id: got %0d exp 0", pk_id); end
    checks++; if (pk_pos !== 6'd5) begin errors++; $display("FAIL tie_pos: got %0d exp 5", pk_pos); end
    checks++; if (corr_en !== 3'b001) begin errors++; $display("FAIL tie_corr: got %b exp 001", corr_en); end
  endtask

  // Detect with E=63, re-acquire across the wrap at pos 0, then lose sync after two empty windows.
  task automatic test_wrap_and_loss();
    do_reset();
    thr = 16'd100;
    for (int i = 0; i <= 259; i++) begin
      int b;
      bit ev;
      b  = (i == 61) ? 150 : (i == 62) ? 200 : (i == 63) ? 300 : (i == 128) ? 400 : 0;
      ev = (i == 64) || (i == 129);
      cycle(1'b1, 0, b, 0);
      checks++; if (pk_vld !== ev) begin errors++; $display("FAIL wrap_vld i=%0d: got %b exp %b", i, pk_vld, ev); end
      checks++; if (lost !== (i == 258)) begin errors++; $display("FAIL loss_pulse i=%0d: got %b exp %b", i, lost, (i == 258)); end
      if (i == 64) begin
        checks++; if ({pk_id, pk_pos, pk_mag} !== {2'd1, 6'd63, 16'd300}) begin
          errors++; $display("FAIL wrap_det: got id=%0d pos=%0d mag=%0d exp 1 63 300", pk_id, pk_pos, pk_mag);
        end
      end
      if (i == 129) begin
        checks++; if ({pk_id, pk_pos, pk_mag} !== {2'd1, 6'd0, 16'd400}) begin
          errors++; $display("FAIL wrap_track: got id=%0d pos=%0d mag=%0d exp 1 0 400", pk_id, pk_pos, pk_mag);
        end
      end
      if (i == 258) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL loss_state: got %0d exp 1", state); end
        checks++; if (corr_en !== 3'b111) begin errors++; $display("FAIL loss_corr: got %b exp 111", corr_en); end
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    thr = 16'd100;
    for (int p = 0; p <= 6; p++) begin
      if (p == 6) search_en = 1'b0;
      cycle(1'b1, 0, 0, (p == 3) ? 500 : 0);
    end
    checks++; if (pk_vld !== 1'b0) begin errors++; $display("FAIL dis_vld: got %b exp 0", pk_vld); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL dis_state: got %0d exp 0", state); end
    checks++; if (corr_en !== 3'b000) begin errors++; $display("FAIL dis_corr: got %b exp 000", corr_en); end
    cycle(1'b1, 900, 900, 900);
    checks++; if ({pk_vld, state} !== 3'b000) begin errors++; $display("FAIL dis_hold: got vld=%b state=%0d exp 0 0", pk_vld, state); end
    search_en = 1'b1;
    cycle(1'b0, 0, 0, 0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL reen_state: got %0d exp 1", state); end
  endtask

  // Random detect + one tracked window; reference works on absolute sample indices.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int th, n_pre, c, r, hi, hk, hm, e, tk, st, j, en, len, bi, bm;
      bit found;
      th    = int'($urandom_range(50, 1000));
      n_pre = int'($urandom_range(0, 70));
      c     = n_pre;
      for (int i = 0; i < n_pre; i++)
        for (int k = 0; k < 3; k++) smp[i][k] = int'($urandom_range(0, th));
      for (int i = c; i <= c + 3; i++) begin
        for (int k = 0; k < 3; k++) smp[i][k] = int'($urandom_range(0, 3 * th));
        if ($urandom_range(0, 3) == 0) smp[i][1] = smp[i][0];
      end
      r = int'($urandom_range(0, 2));
      smp[c][r] = int'($urandom_range(th + 1, 3 * th));
      hm = -1; hi = 0; hk = 0;
      for (int i = c; i <= c + 3; i++)
        for (int k = 0; k < 3; k++)
          if (smp[i][k] > hm) begin hm = smp[i][k]; hi = i; hk = k; end
      e  = hi % 64;
      tk = hk;
      st = (e + 62) % 64;
      j  = c + 4;
      while (j % 64 != st) j++;
      en  = j + 4;
      len = en + 4;
      for (int i = c + 4; i < len; i++) begin
        for (int k = 0; k < 3; k++) smp[i][k] = int'($urandom_range(0, 3 * th));
        smp[i][tk] = int'($urandom_range(0, th + th / 2));
      end
      found = 1'b0; bm = th; bi = 0;
      for (int i = j; i <= en; i++)
        if (smp[i][tk] > bm) begin bm = smp[i][tk]; bi = i; found = 1'b1; end

      do_reset();
      thr = 16'(th);
      for (int i = 0; i < len; i++) begin
        bit ev;
        int eid, epos, emag;
        if ($urandom_range(0, 4) == 0) begin
          cycle(1'b0, int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)));
          checks++; if (pk_vld !== 1'b0) begin errors++; $display("FAIL rnd_gap it=%0d i=%0d: got vld=%b exp 0", it, i, pk_vld); end
        end
        cycle(1'b1, smp[i][0], smp[i][1], smp[i][2]);
        ev = 1'b0; eid = 0; epos = 0; emag = 0;
        if (i == c + 3) begin ev = 1'b1; eid = hk; epos = e; emag = hm; end
        else if (i == en && found) begin ev = 1'b1; eid = tk; epos = bi % 64; emag = bm; end
        checks++; if (pk_vld !== ev) begin errors++; $display("FAIL rnd_vld it=%0d i=%0d: got %b exp %b", it, i, pk_vld, ev); end
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL rnd_lost it=%0d i=%0d: got %b exp 0", it, i, lost); end
        if (ev) begin
          checks++; if ({pk_id, pk_pos, pk_mag} !== {2'(eid), 6'(epos), 16'(emag)}) begin
            errors++; $display("FAIL rnd_peak it=%0d i=%0d: got id=%0d pos=%0d mag=%0d exp id=%0d pos=%0d mag=%0d",
                               it, i, pk_id, pk_pos, pk_mag, eid, epos, emag);
          end
        end
      end
      checks++; if (corr_en !== 3'(1 << tk)) begin errors++; $display("FAIL rnd_corr it=%0d: got %b exp %b", it, corr_en, 3'(1 << tk)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; search_en = 1'b0; thr = '0; tdata = '0; tvalid = 1'b0;
    test_reset();
    test_detection();
    test_tie();
    test_wrap_and_loss();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
